rs_decoder_checker: RTL
=======================

Name: rs_decoder_checker

Overview:
- Receive-side counterpart of the RS encoder. Accepts one RS(N,K) codeword over GF(2^8), one symbol per cycle, and computes 2T syndromes on the fly.
- Replays the K message symbols on the output with an error flag that covers the whole codeword.
- Uses the same alternating ready/valid phase protocol as the encoder: exactly one of the two strobes is high at any time outside reset.
- Sits at the channel end of the RS test chain, directly fed by the encoder's output stream.

Parameters:
- SYM_W, 8, symbol width in bits; GF(2^8), primitive polynomial 0x11D.
- N_SYM, 20, codeword length in symbols (receive phase length in cycles).
- K_SYM, 16, message length in symbols (send phase length in cycles).
- NSYND, 4, number of syndromes (N_SYM-K_SYM); generator roots are alpha^0 to alpha^(NSYND-1).

Ports:
- clock, input, 1, sole clock; all logic on posedge.
- reset, input, 1, synchronous, active-high.
- decoderInputPort, input, SYM_W, received codeword symbol; sampled on each posedge while decoderReadyPort=1.
- decoderReadyPort, output, 1, registered; high for exactly N_SYM cycles per codeword (receive phase).
- decoderValidPort, output, 1, registered; high for exactly K_SYM cycles per codeword (send phase).
- dataOutputPort, output, SYM_W, registered message symbol; meaningful while decoderValidPort=1.
- errorFlagPort, output, 1, registered; 1 if any syndrome is nonzero; stable through the whole send phase.

Behaviour:
- Reset: while reset=1, at every posedge set decoderReadyPort=0, decoderValidPort=0, dataOutputPort=0, errorFlagPort=0, all syndromes=0, counter=0, state=RECEIVE. Reset asserted mid-phase aborts the codeword; no partial output is produced.
- First posedge with reset=0 raises decoderReadyPort. From then on, ready and valid are never both 0 and never both 1.
- RECEIVE state:
  - Each posedge with ready=1 samples decoderInputPort into buffer[cnt] (only for cnt<K_SYM) and updates every syndrome: S_j <= gf_mul(S_j, alpha^j) XOR symbol.
  - The first symbol received is the highest-degree coefficient. Message symbols come first, then N_SYM-K_SYM parity symbols.
  - cnt increments 0..N_SYM-1.
  - On the posedge sampling cnt=N_SYM-1: ready<=0, valid<=1, errorFlagPort<=OR over j of (next S_j != 0), dataOutputPort<=buffer[0], cnt<=0, state<=SEND.
  - The error flag therefore appears together with valid; the end-of-codeword to first-output latency is one cycle.
- SEND state:
  - Each posedge advances cnt; dataOutputPort<=buffer[cnt+1]. Valid stays high for K_SYM posedges.
  - On the last one: valid<=0, ready<=1, syndromes<=0, cnt<=0, state<=RECEIVE.
  - Phases run back-to-back with no idle cycle. decoderInputPort is ignored during SEND.
- Arithmetic: constant GF multiply by alpha^j is pure XOR logic reduced by 0x11D. Syndromes are SYM_W bits; no carries.
- No correction is performed. dataOutputPort carries the received message symbols unchanged, even when errorFlagPort=1.
- errorFlagPort holds its value until the next RECEIVE→SEND transition or reset.

Decomposition:
- Package rs_pkg:
  - SYM_W, N_SYM, K_SYM, NSYND, GF_POLY=0x11D;
  - typedef symbol_t;
  - state enum {RECEIVE, SEND};
  - function gf_mul_alpha_pow(symbol_t, int j);
  - alpha power constant table.
- This package is shared with the encoder.
- Sub-module rs_syndrome_cell (one instance per root): holds S_j, takes clear/enable/symbol, parameter ROOT_IDX.

Test Plan:
- Reset for 3 cycles, then release → ready=1 on the first posedge after release; valid=0; ready high exactly 20 cycles, then valid high exactly 16 cycles, repeating; ready and valid never both 0 or both 1 (checked every cycle).
- All-zero codeword → dataOutputPort=0x00 for 16 cycles, errorFlagPort=0.
- Encoder output for message 0x01..0x10 fed in → dataOutputPort emits 0x01..0x10 in order, errorFlagPort=0.
- Same codeword with symbol 5 XORed with 0x40 → same output 0x01..0x10 except symbol 5 = 0x45; errorFlagPort=1 for all 16 valid cycles.
- Codeword of 19 zeros then 0x01 → S0..S3=0x01, errorFlagPort=1, data all 0x00.
- Reset asserted on the 8th receive cycle for 1 cycle → all outputs 0 the next cycle. A following full valid codeword decodes with errorFlagPort=0, proving the syndromes were cleared.

Source files
------------

// File: rtl/rs_decoder_checker_pkg.sv
// Shared RS(20,16) definitions over GF(2^8) for the encoder and decoder checker.
// Latency: n/a (types, constants and pure combinational helpers).
// Backpressure: n/a.
package rs_pkg;

    localparam int SYM_W = 8;
    localparam int N_SYM = 20;
    localparam int K_SYM = 16;
    localparam int NSYND = N_SYM - K_SYM;

    // Field polynomial x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [SYM_W:0] GF_POLY = 9'h11D;

    typedef logic [SYM_W-1:0] symbol_t;

    typedef enum logic {
        RECEIVE = 1'b0,
        SEND    = 1'b1
    } state_t;

    // Generator roots alpha^0 .. alpha^(NSYND-1)
    localparam symbol_t ALPHA_POW [NSYND] = '{8'h01, 8'h02, 8'h04, 8'h08};

    // Multiply by alpha: shift left, fold the overflow bit back through the field polynomial.
    function automatic symbol_t gf_xtime(symbol_t s);
        symbol_t sh;
        sh = {s[SYM_W-2:0], 1'b0};
        return s[SYM_W-1] ? (sh ^ GF_POLY[SYM_W-1:0]) : sh;
    endfunction

    // Multiply by alpha^j; with constant j this collapses to a fixed XOR network.
    function automatic symbol_t gf_mul_alpha_pow(symbol_t s, int j);
        symbol_t r;
        r = s;
        for (int i = 0; i < j; i++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_decoder_checker_if.sv
// Symbol stream bundle between the channel side and the decoder checker.
// Latency: n/a (wires only).
// Backpressure: alternating phases; ready marks receive, valid marks send.
interface rs_decoder_checker_if;
    import rs_pkg::*;

    symbol_t decoderInputPort;
    logic    decoderReadyPort;
    logic    decoderValidPort;
    symbol_t dataOutputPort;
    logic    errorFlagPort;

    // master: drives received symbols and consumes the replayed message
    modport master (
        output decoderInputPort,
        input  decoderReadyPort,
        input  decoderValidPort,
        input  dataOutputPort,
        input  errorFlagPort
    );

    // slave: the decoder checker itself
    modport slave (
        input  decoderInputPort,
        output decoderReadyPort,
        output decoderValidPort,
        output dataOutputPort,
        output errorFlagPort
    );
endinterface

// File: rtl/rs_syndrome_cell.sv
// One syndrome accumulator S_j = r(alpha^j), evaluated by Horner's rule, highest degree first.
// Latency: 1 cycle per symbol; synd_next is the combinational value S_j takes on enable.
// Backpressure: none; updates only when enable is high, clear has priority.
// Ports: clock, clear (sync), enable, symbol in; synd_next out.
module rs_syndrome_cell
    import rs_pkg::*;
#(
    parameter int ROOT_IDX = 0
) (
    input  logic    clock,
    input  logic    clear,
    input  logic    enable,
    input  symbol_t symbol,
    output symbol_t synd_next
);

    symbol_t synd;

    always_comb begin
        synd_next = gf_mul_alpha_pow(synd, ROOT_IDX) ^ symbol;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            synd <= '0;
        end else if (enable) begin
            synd <= synd_next;
        end
    end

endmodule

// File: rtl/rs_decoder_checker.sv
// RS(20,16) receive checker: accumulates syndromes, replays the 16 message symbols with an error flag.
// Latency: first message symbol one cycle after the last codeword symbol is sampled.
// Backpressure: none; fixed 20-cycle receive phase (ready) then 16-cycle send phase (valid), back to back.
// Ports: clock, reset (sync, active-high), dif (slave: input symbol, ready/valid, data, error flag).
module rs_decoder_checker
    import rs_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    rs_decoder_checker_if.slave  dif
);

    localparam int CW = $clog2(N_SYM);
    localparam int BW = $clog2(K_SYM);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            ready, ready_n;
    logic            valid, valid_n;
    symbol_t         data, data_n;
    logic            flag, flag_n;
    logic            synd_clr, synd_en;
    logic            any_err;
    logic [BW-1:0]   rd_idx;
    symbol_t         buffer [K_SYM];
    symbol_t         synd_next [NSYND];

    for (genvar j = 0; j < NSYND; j++) begin : g_synd
        rs_syndrome_cell #(.ROOT_IDX(j)) u_cell (
            .clock     (clock),
            .clear     (reset | synd_clr),
            .enable    (synd_en),
            .symbol    (dif.decoderInputPort),
            .synd_next (synd_next[j])
        );
    end

    // Flag is taken from the post-update syndromes so it lands together with valid.
    always_comb begin
        any_err = 1'b0;
        for (int j = 0; j < NSYND; j++) begin
            any_err = any_err | (synd_next[j] != '0);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ready_n  = ready;
        valid_n  = valid;
        data_n   = data;
        flag_n   = flag;
        synd_clr = 1'b0;
        synd_en  = 1'b0;
        rd_idx   = BW'(cnt + CW'(1));
        case (state)
            RECEIVE: begin
                if (!ready) begin
                    // first cycle out of reset: open the receive phase
                    ready_n = 1'b1;
                end else begin
                    synd_en = 1'b1;
                    if (cnt == CW'(N_SYM - 1)) begin
                        ready_n = 1'b0;
                        valid_n = 1'b1;
                        flag_n  = any_err;
                        data_n  = buffer[0];
                        cnt_n   = '0;
                        state_n = SEND;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            SEND: begin
                if (cnt == CW'(K_SYM - 1)) begin
                    valid_n  = 1'b0;
                    ready_n  = 1'b1;
                    synd_clr = 1'b1;
                    cnt_n    = '0;
                    state_n  = RECEIVE;
                end else begin
                    cnt_n  = cnt + CW'(1);
                    data_n = buffer[rd_idx];
                end
            end
            default: state_n = RECEIVE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RECEIVE;
            cnt   <= '0;
            ready <= 1'b0;
            valid <= 1'b0;
            data  <= '0;
            flag  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ready <= ready_n;
            valid <= valid_n;
            data  <= data_n;
            flag  <= flag_n;
        end
    end

    // Message buffer needs no reset: it is only read after a full receive phase has refilled it.
    always_ff @(posedge clock) begin
        if (!reset && state == RECEIVE && ready && cnt < CW'(K_SYM)) begin
            buffer[cnt[BW-1:0]] <= dif.decoderInputPort;
        end
    end

    assign dif.decoderReadyPort = ready;
    assign dif.decoderValidPort = valid;
    assign dif.dataOutputPort   = data;
    assign dif.errorFlagPort    = flag;

endmodule
